// File: rtl/rs_ff_bank_pkg.sv
// -----------------------------------------------------------------------------
// rs_ff_bank_pkg
// Shared definitions for the RS register bank:
//   - S=R=1 resolution mode constants (hold / set-dominant / reset-dominant /
//     toggle)
//   - maximum supported channel count
//   - rs_next_state(): per-channel next-state function used by rs_cell
// -----------------------------------------------------------------------------
package rs_ff_bank_pkg;

    localparam int RS_MODE_HOLD = 0;
    localparam int RS_MODE_SET  = 1;
    localparam int RS_MODE_RST  = 2;
    localparam int RS_MODE_TGL  = 3;

    localparam int RS_MAX_WIDTH = 32;

    // Next state of one channel for an enabled, non-load cycle.
    function automatic logic rs_next_state(
        input logic q,
        input logic s,
        input logic r,
        input int   mode
    );
        logic nxt;
        nxt = q;
        if (s && !r) begin
            nxt = 1'b1;
        end else if (!s && r) begin
            nxt = 1'b0;
        end else if (s && r) begin
            if (mode == RS_MODE_SET) begin
                nxt = 1'b1;
            end else if (mode == RS_MODE_RST) begin
                nxt = 1'b0;
            end else if (mode == RS_MODE_TGL) begin
                nxt = ~q;
            end else begin
                nxt = q;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rs_ff_bank_cell.sv
// -----------------------------------------------------------------------------
// rs_cell
// One channel of the RS register bank: next-state mux, state register,
// registered edge pulses and the sticky conflict flag.
//
// Parameters
//   MODE          S=R=1 resolution (see rs_ff_bank_pkg mode constants)
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset, highest priority
//   en            clock enable; low freezes q/conflict and zeroes rise/fall
//   s, r          set / reset requests
//   ld, ld_data   parallel load (overrides s/r)
//   clr_conflict  clears the sticky conflict flag (honoured even when en=0)
//   q             registered state
//   rise, fall    1-cycle pulses coincident with the new q
//   conflict      sticky flag: s=r=1 seen while enabled and not loading
// -----------------------------------------------------------------------------
module rs_cell
    import rs_ff_bank_pkg::*;
#(
    parameter int MODE = RS_MODE_HOLD
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic s,
    input  logic r,
    input  logic ld,
    input  logic ld_data,
    input  logic clr_conflict,
    output logic q,
    output logic rise,
    output logic fall,
    output logic conflict
);

    logic q_q, q_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;
    logic conf_q, conf_d;

    always_comb begin
        q_d    = q_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        // Clear first so that a fresh conflict in the same cycle re-sets it.
        conf_d = conf_q & ~clr_conflict;
        if (en) begin
            if (ld) begin
                q_d = ld_data;
            end else begin
                q_d = rs_next_state(q_q, s, r, MODE);
                if (s && r) begin
                    conf_d = 1'b1;
                end
            end
            // Edges are computed against the next state so the pulse lands
            // in the same cycle as the new q.
            rise_d = ~q_q & q_d;
            fall_d = q_q & ~q_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            conf_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            conf_q <= conf_d;
        end
    end

    assign q        = q_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign conflict = conf_q;

endmodule

// File: rtl/rs_ff_bank.sv
// -----------------------------------------------------------------------------
// rs_ff_bank
// WIDTH-channel clocked set/reset register bank with selectable S=R=1
// resolution, parallel load, clock enable, registered edge pulses and sticky
// per-channel conflict flags.
//
// Optional feature macro: RS_BANK_EVENT_CNT_EN
//   When defined, each channel has a saturating CNT_W-bit counter of rise
//   pulses, readable through cnt_sel/cnt_out and cleared with clr_cnt.
//
// Parameters
//   WIDTH   number of channels (1..RS_MAX_WIDTH)
//   MODE    S=R=1 resolution: 0 hold, 1 set, 2 reset, 3 toggle
//   CNT_W   event counter width (counter build only)
// Ports
//   clk, rst           clock, synchronous active-high reset
//   en                 clock enable
//   s, r               per-channel set / reset requests
//   ld, ld_data        parallel load of all channels
//   clr_conflict       clears all sticky conflict flags
//   q, nq              registered state and its complement
//   rise, fall         registered 0->1 / 1->0 pulses
//   conflict           sticky per-channel s=r=1 flags
//   cnt_sel            counter readout select       (counter build only)
//   clr_cnt            zero all counters            (counter build only)
//   cnt_out            counter[cnt_sel], 0 if out of range (counter build only)
// -----------------------------------------------------------------------------
module rs_ff_bank
    import rs_ff_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = RS_MODE_HOLD,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [WIDTH-1:0]     s,
    input  logic [WIDTH-1:0]     r,
    input  logic                 ld,
    input  logic [WIDTH-1:0]     ld_data,
    input  logic                 clr_conflict,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     nq,
    output logic [WIDTH-1:0]     rise,
    output logic [WIDTH-1:0]     fall,
    output logic [WIDTH-1:0]     conflict
`ifdef RS_BANK_EVENT_CNT_EN
    ,
    input  logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] cnt_sel,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     cnt_out
`endif
);

    // Elaboration-time parameter checks.
    if (MODE < RS_MODE_HOLD || MODE > RS_MODE_TGL) begin : g_bad_mode
        $error("rs_ff_bank: illegal MODE %0d", MODE);
    end
    if (WIDTH < 1 || WIDTH > RS_MAX_WIDTH) begin : g_bad_width
        $error("rs_ff_bank: illegal WIDTH %0d", WIDTH);
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("rs_ff_bank: illegal CNT_W %0d", CNT_W);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        rs_cell #(
            .MODE(MODE)
        ) u_cell (
            .clk          (clk),
            .rst          (rst),
            .en           (en),
            .s            (s[i]),
            .r            (r[i]),
            .ld           (ld),
            .ld_data      (ld_data[i]),
            .clr_conflict (clr_conflict),
            .q            (q[i]),
            .rise         (rise[i]),
            .fall         (fall[i]),
            .conflict     (conflict[i])
        );
    end

    // Derived from the register, so it is ~q in every cycle including reset.
    assign nq = ~q;

`ifdef RS_BANK_EVENT_CNT_EN
    localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Counts the registered rise pulse, so a counter advances on the edge
    // after its pulse becomes visible; clr_cnt drops any such pulse.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr_cnt) begin
                cnt_d[i] = '0;
            end else if (rise[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Selects outside 0..WIDTH-1 match no channel and read as zero.
    always_comb begin
        cnt_out = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (32'(cnt_sel) == i) begin
                cnt_out = cnt_q[i];
            end
        end
    end

    logic unused_sel_w;
    assign unused_sel_w = (SEL_W == 0);
`endif

endmodule

// File: tb/tb_rs_ff_bank.sv
// -----------------------------------------------------------------------------
// tb_rs_ff_bank
// Four 8-channel banks, one per MODE, share the same stimulus. Each directed
// step carries hand-computed q for all four modes plus the conflict value;
// rise/fall/nq expectations follow from consecutive expected q values.
// A monitor pops one expectation per clock edge and compares.
// -----------------------------------------------------------------------------
module tb_rs_ff_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] s = '0;
    logic [7:0] r = '0;
    logic       ld = 1'b0;
    logic [7:0] ld_data = '0;
    logic       clr_conflict = 1'b0;

    logic [7:0] q_o    [4];
    logic [7:0] nq_o   [4];
    logic [7:0] rise_o [4];
    logic [7:0] fall_o [4];
    logic [7:0] conf_o [4];

`ifdef RS_BANK_EVENT_CNT_EN
    logic [2:0] cnt_sel = 3'd3;
    logic       clr_cnt = 1'b0;
    logic [1:0] cnt_o [4];
`endif

    for (genvar m = 0; m < 4; m++) begin : g_dut
        rs_ff_bank #(
            .WIDTH(8),
            .MODE (m),
            .CNT_W(2)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .en           (en),
            .s            (s),
            .r            (r),
            .ld           (ld),
            .ld_data      (ld_data),
            .clr_conflict (clr_conflict),
            .q            (q_o[m]),
            .nq           (nq_o[m]),
            .rise         (rise_o[m]),
            .fall         (fall_o[m]),
            .conflict     (conf_o[m])
`ifdef RS_BANK_EVENT_CNT_EN
            ,
            .cnt_sel      (cnt_sel),
            .clr_cnt      (clr_cnt),
            .cnt_out      (cnt_o[m])
`endif
        );
    end

    typedef struct packed {
        logic [31:0] q;      // {mode3, mode2, mode1, mode0}
        logic [31:0] rise;
        logic [31:0] fall;
        logic [7:0]  conf;
        logic        cnt_chk;
        logic [1:0]  cnt;
        int          idx;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] prev_q [4] = '{default: 8'h00};
    int         checks = 0;
    int         failures = 0;
    int         step_no = 0;

    task automatic chk(input string name, input int idx, input int m,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d mode=%0d actual=%02h required=%02h",
                     name, idx, m, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the edge.
    task automatic step(input logic i_rst, input logic i_en,
                        input logic [7:0] i_s, input logic [7:0] i_r,
                        input logic i_ld, input logic [7:0] i_ldd,
                        input logic i_clr,
                        input logic [31:0] eq, input logic [7:0] econf,
                        input logic i_clrcnt = 1'b0,
                        input logic ecnt_chk = 1'b0,
                        input logic [1:0] ecnt = 2'd0);
        exp_t       e;
        logic [7:0] nw;
        @(negedge clk);
        rst          = i_rst;
        en           = i_en;
        s            = i_s;
        r            = i_r;
        ld           = i_ld;
        ld_data      = i_ldd;
        clr_conflict = i_clr;
`ifdef RS_BANK_EVENT_CNT_EN
        clr_cnt      = i_clrcnt;
`endif
        e         = '0;
        e.q       = eq;
        e.conf    = econf;
        e.cnt_chk = ecnt_chk & ~i_clrcnt | ecnt_chk;
        e.cnt     = ecnt;
        e.idx     = step_no;
        for (int m = 0; m < 4; m++) begin
            nw = eq[m*8 +: 8];
            if (!i_rst && i_en) begin
                e.rise[m*8 +: 8] = ~prev_q[m] & nw;
                e.fall[m*8 +: 8] = prev_q[m] & ~nw;
            end
            prev_q[m] = nw;
        end
        sb.push_back(e);
        step_no++;
    endtask

    // Monitor: every edge with a pending expectation is checked.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int m = 0; m < 4; m++) begin
                    chk("q",        e.idx, m, q_o[m],    e.q[m*8 +: 8]);
                    chk("nq",       e.idx, m, nq_o[m],   ~e.q[m*8 +: 8]);
                    chk("rise",     e.idx, m, rise_o[m], e.rise[m*8 +: 8]);
                    chk("fall",     e.idx, m, fall_o[m], e.fall[m*8 +: 8]);
                    chk("conflict", e.idx, m, conf_o[m], e.conf);
                end
`ifdef RS_BANK_EVENT_CNT_EN
                if (e.cnt_chk) begin
                    chk("cnt_out", e.idx, 0, {6'd0, cnt_o[0]}, {6'd0, e.cnt});
                end
`endif
            end
        end
    end

    initial begin
        // Reset, then idle
        step(1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 32'h00000000, 8'h00);
        step(1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 32'h00000000, 8'h00);
        step(0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 32'h00000000, 8'h00);
        // Set / reset
        step(0, 1, 8'h05, 8'h00, 0, 8'h00, 0, 32'h05050505, 8'h00);
        step(0, 1, 8'h00, 8'h01, 0, 8'h00, 0, 32'h04040404, 8'h00);
        step(0, 1, 8'h00, 8'h04, 0, 8'h00, 0, 32'h00000000, 8'h00);
        // S=R=1 on channel 7 in each mode; sticky conflict and its clear
        step(0, 1, 8'h80, 8'h80, 0, 8'h00, 0, 32'h80008000, 8'h80);
        step(0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 32'h80008000, 8'h80);
        step(0, 1, 8'h00, 8'h00, 0, 8'h00, 1, 32'h80008000, 8'h00);
        step(0, 1, 8'h80, 8'h80, 0, 8'h00, 1, 32'h00008000, 8'h80);
        step(0, 1, 8'h00, 8'h00, 0, 8'h00, 1, 32'h00008000, 8'h00);
        step(0, 1, 8'h00, 8'h80, 0, 8'h00, 0, 32'h00000000, 8'h00);
        // Held S=R=1 on channel 0 with an enable gap
        step(0, 1, 8'h01, 8'h01, 0, 8'h00, 0, 32'h01000100, 8'h01);
        step(0, 1, 8'h01, 8'h01, 0, 8'h00, 0, 32'h00000100, 8'h01);
        step(0, 0, 8'h01, 8'h01, 0, 8'h00, 0, 32'h00000100, 8'h01);
        step(0, 0, 8'h01, 8'h01, 0, 8'h00, 1, 32'h00000100, 8'h00);
        step(0, 1, 8'h01, 8'h01, 0, 8'h00, 0, 32'h01000100, 8'h01);
        step(0, 1, 8'h01, 8'h01, 0, 8'h00, 0, 32'h00000100, 8'h01);
        step(0, 0, 8'hFF, 8'h00, 0, 8'h00, 0, 32'h00000100, 8'h01);
        step(0, 1, 8'h00, 8'h01, 0, 8'h00, 0, 32'h00000000, 8'h01);
        // Parallel load overrides s/r and records no conflict
        step(0, 1, 8'hFF, 8'h00, 1, 8'hA5, 0, 32'hA5A5A5A5, 8'h01);
        step(0, 1, 8'hFF, 8'hFF, 1, 8'hA5, 0, 32'hA5A5A5A5, 8'h01);
        // Reset wins over load
        step(1, 1, 8'hFF, 8'h00, 1, 8'h3C, 0, 32'h00000000, 8'h00);
        step(0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 32'h00000000, 8'h00);
`ifdef RS_BANK_EVENT_CNT_EN
        // Channel 3 rises five times; counter lags its pulse by one edge
        step(0, 1, 8'h08, 8'h00, 0, 8'h00, 0, 32'h08080808, 8'h00, 0, 1, 2'd0);
        step(0, 1, 8'h00, 8'h08, 0, 8'h00, 0, 32'h00000000, 8'h00, 0, 1, 2'd1);
        step(0, 1, 8'h08, 8'h00, 0, 8'h00, 0, 32'h08080808, 8'h00, 0, 1, 2'd1);
        step(0, 1, 8'h00, 8'h08, 0, 8'h00, 0, 32'h00000000, 8'h00, 0, 1, 2'd2);
        step(0, 1, 8'h08, 8'h00, 0, 8'h00, 0, 32'h08080808, 8'h00, 0, 1, 2'd2);
        step(0, 1, 8'h00, 8'h08, 0, 8'h00, 0, 32'h00000000, 8'h00, 0, 1, 2'd3);
        step(0, 1, 8'h08, 8'h00, 0, 8'h00, 0, 32'h08080808, 8'h00, 0, 1, 2'd3);
        step(0, 1, 8'h00, 8'h08, 0, 8'h00, 0, 32'h00000000, 8'h00, 0, 1, 2'd3);
        step(0, 1, 8'h08, 8'h00, 0, 8'h00, 0, 32'h08080808, 8'h00, 0, 1, 2'd3);
        step(0, 1, 8'h00, 8'h08, 0, 8'h00, 0, 32'h00000000, 8'h00, 0, 1, 2'd3);
        step(0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 32'h00000000, 8'h00, 0, 1, 2'd3);
        step(0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 32'h00000000, 8'h00, 1, 1, 2'd0);
        // A rise pulse coinciding with clr_cnt is dropped
        step(0, 1, 8'h08, 8'h00, 0, 8'h00, 0, 32'h08080808, 8'h00, 0, 1, 2'd0);
        step(0, 1, 8'h00, 8'h08, 0, 8'h00, 0, 32'h00000000, 8'h00, 1, 1, 2'd0);
        step(0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 32'h00000000, 8'h00, 0, 1, 2'd0);
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
